// File: rtl/seq_notas.sv
`default_nettype none
// ============================================================================
// seq_notas : buffers a phrase of notes, replays it into the note classifier
//             with spaced ok strobes, then reports the classifier's tipo.
// Rev 1.0
// ============================================================================
module seq_notas #(
    parameter int DEPTH   = 8,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [2:0] nota_in,
    input  logic       tom_in,
    input  logic       start,
    input  logic       fim_cls,
    input  logic [1:0] tipo_cls,
    output logic       rst_cls,
    output logic       ok_cls,
    output logic [2:0] nota_cls,
    output logic       tom_cls,
    output logic       busy,
    output logic       done,
    output logic [1:0] tipo_out,
    output logic [3:0] count,
    output logic       full,
    output logic       err
);
    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SEND  = 3'd2,
        S_GAP   = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q;
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [CW-1:0] cnt_q;
    logic          tom_q;
    logic [2:0]    gap_q;
    logic [7:0]    tmo_q;

    logic          rst_cls_q;
    logic          ok_cls_q;
    logic [2:0]    nota_cls_q;
    logic          tom_cls_q;
    logic          busy_q;
    logic          done_q;
    logic [1:0]    tipo_q;
    logic          err_q;

    logic          full_d;
    logic          wr_acc_d;
    logic          fim_take_d;
    logic [CW-1:0] cnt_wr_d;
    logic [AW-1:0] rp_nx_d;

    assign full_d     = (cnt_q == DEPTH_C);
    assign wr_acc_d   = (state_q == S_IDLE) && wr && !full_d;
    assign cnt_wr_d   = wr_acc_d ? (cnt_q + ONE_C) : cnt_q;
    assign rp_nx_d    = rp_q + AW'(1);
    assign fim_take_d = fim_cls &&
                        ((state_q == S_SEND) || (state_q == S_GAP) || (state_q == S_WAIT));

    // Note storage carries no reset: occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (wr_acc_d) begin
            mem_q[wp_q] <= nota_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            tom_q      <= 1'b0;
            gap_q      <= '0;
            tmo_q      <= '0;
            rst_cls_q  <= 1'b0;
            ok_cls_q   <= 1'b0;
            nota_cls_q <= '0;
            tom_cls_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tipo_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            rst_cls_q <= 1'b0;
            ok_cls_q  <= 1'b0;
            done_q    <= 1'b0;

            if (fim_take_d) begin
                // Early or on-time result: drop whatever is left of the phrase.
                tipo_q  <= tipo_cls;
                cnt_q   <= '0;
                rp_q    <= wp_q;
                done_q  <= 1'b1;
                state_q <= S_DONE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        cnt_q <= cnt_wr_d;
                        if (wr_acc_d) begin
                            wp_q <= wp_q + AW'(1);
                            if (cnt_q == '0) begin
                                tom_q <= tom_in;
                            end
                        end
                        if (start && (cnt_wr_d != '0)) begin
                            err_q     <= 1'b0;
                            rst_cls_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= S_CLEAR;
                        end else if (wr && full_d) begin
                            err_q <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        ok_cls_q   <= 1'b1;
                        nota_cls_q <= mem_q[rp_q];
                        tom_cls_q  <= tom_q;
                        state_q    <= S_SEND;
                    end
                    S_SEND: begin
                        rp_q  <= rp_nx_d;
                        cnt_q <= cnt_q - ONE_C;
                        if (cnt_q == ONE_C) begin
                            tmo_q   <= '0;
                            state_q <= S_WAIT;
                        end else if (GAP == 0) begin
                            ok_cls_q   <= 1'b1;
                            nota_cls_q <= mem_q[rp_nx_d];
                            state_q    <= S_SEND;
                        end else begin
                            gap_q   <= '0;
                            state_q <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (gap_q == 3'(GAP - 1)) begin
                            ok_cls_q   <= 1'b1;
                            nota_cls_q <= mem_q[rp_q];
                            state_q    <= S_SEND;
                        end else begin
                            gap_q <= gap_q + 3'd1;
                        end
                    end
                    S_WAIT: begin
                        if (tmo_q == 8'(TIMEOUT)) begin
                            tipo_q  <= 2'b00;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            tmo_q <= tmo_q + 8'd1;
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // The count port is 4 bits wide; a completely full 16-deep buffer reads 0 with full set.
    generate
        if (CW >= 4) begin : g_cnt_trunc
            assign count = cnt_q[3:0];
        end else begin : g_cnt_ext
            assign count = {{(4 - CW){1'b0}}, cnt_q};
        end
    endgenerate

    assign rst_cls  = rst_cls_q;
    assign ok_cls   = ok_cls_q;
    assign nota_cls = nota_cls_q;
    assign tom_cls  = tom_cls_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tipo_out = tipo_q;
    assign full     = full_d;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_notas.sv
`default_nettype none
// ============================================================================
// tb_seq_notas : randomized scoreboard bench for seq_notas; expected events come
//                from a queue model of the phrase buffer and the timing rules.
// Rev 1.0
// ============================================================================
module tb_seq_notas;
    localparam int DEPTH   = 8;
    localparam int GAP     = 1;
    localparam int TIMEOUT = 15;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       wr       = 1'b0;
    logic [2:0] nota_in  = 3'd0;
    logic       tom_in   = 1'b0;
    logic       start    = 1'b0;
    logic       fim_cls  = 1'b0;
    logic [1:0] tipo_cls = 2'd0;
    logic       rst_cls, ok_cls, tom_cls, busy, done, full, err;
    logic [2:0] nota_cls;
    logic [1:0] tipo_out;
    logic [3:0] count;

    seq_notas #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr(wr), .nota_in(nota_in), .tom_in(tom_in),
        .start(start), .fim_cls(fim_cls), .tipo_cls(tipo_cls),
        .rst_cls(rst_cls), .ok_cls(ok_cls), .nota_cls(nota_cls), .tom_cls(tom_cls),
        .busy(busy), .done(done), .tipo_out(tipo_out), .count(count),
        .full(full), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = classifier reset pulse, 1 = ok strobe, 2 = done
    typedef struct {
        int kind;
        int cyc;
        int nota;
        int tom;
        int tipo;
        int err;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    int  mdl[$];
    int  mdl_tom = 0;
    int  mdl_err = 0;
    int  last_tipo = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int nota, input int tom,
                           input int tipo, input int e);
        ev_t ev;
        ev.kind = kind; ev.cyc = c; ev.nota = nota; ev.tom = tom; ev.tipo = tipo; ev.err = e;
        sb.push_back(ev);
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        int  k;
        if (!reset && (rst_cls || ok_cls || done)) begin
            k = rst_cls ? 0 : (ok_cls ? 1 : 2);
            if (sb.size() == 0) begin
                chk("unexpected_event_kind", k, -1);
            end else begin
                e = sb.pop_front();
                chk("event_kind", k, e.kind);
                chk("event_cycle", cyc, e.cyc);
                if (e.kind == 1) begin
                    chk("ok_nota", int'(nota_cls), e.nota);
                    chk("ok_tom", int'(tom_cls), e.tom);
                end
                if (e.kind == 2) begin
                    chk("done_tipo", int'(tipo_out), e.tipo);
                    chk("done_err", int'(err), e.err);
                    chk("done_count", int'(count), 0);
                    chk("done_busy", int'(busy), 1);
                end
            end
        end
    end

    // Entered and left at a falling edge; consecutive calls write back to back.
    task automatic write_note(input int n, input int t);
        wr = 1'b1; nota_in = 3'(n); tom_in = t[0];
        if (mdl.size() < DEPTH) begin
            if (mdl.size() == 0) mdl_tom = t;
            mdl.push_back(n);
        end else begin
            mdl_err = 1;
        end
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_count"}, int'(count), mdl.size());
        chk({tag, "_full"}, int'(full), (mdl.size() == DEPTH) ? 1 : 0);
        chk({tag, "_err"}, int'(err), mdl_err);
    endtask

    // foff < 0: classifier never answers; otherwise fim is high in cycle S+foff.
    task automatic run_phrase(input int foff, input int tp);
        int s, n, l, f, oc, guard, tmo;
        n = mdl.size();
        s = cyc + 1;
        l = s + 1 + (n - 1) * (GAP + 1);
        f = (foff < 0) ? -1 : s + foff;
        tmo = (f < 0 || f > l + TIMEOUT + 1) ? 1 : 0;
        push_ev(0, s, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) begin
            oc = s + 1 + k * (GAP + 1);
            if (tmo == 1 || oc <= f) push_ev(1, oc, mdl[k], mdl_tom, 0, 0);
        end
        if (tmo == 1) begin
            push_ev(2, l + TIMEOUT + 2, 0, 0, 0, 1);
            last_tipo = 0;
        end else begin
            push_ev(2, f + 1, 0, 0, tp, 0);
            last_tipo = tp;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_cleared_by_start", int'(err), 0);
        chk("busy_after_start", int'(busy), 1);
        mdl.delete();
        mdl_err = tmo;
        if (f >= 0 && tmo == 0) begin
            guard = 0;
            while (cyc < f && guard < 1000) begin
                wr = 1'($urandom_range(0, 1));
                nota_in = 3'($urandom_range(0, 7));
                @(negedge clk);
                guard++;
            end
            wr = 1'b0;
            fim_cls = 1'b1; tipo_cls = 2'(tp);
            @(negedge clk);
            fim_cls = 1'b0; tipo_cls = 2'($urandom_range(0, 3));
        end
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            chk("scoreboard_drain_left", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        chk("tipo_held", int'(tipo_out), last_tipo);
        check_regs("post_phrase");
    endtask

    initial begin
        int n, lmax;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_rst_cls", int'(rst_cls), 0);
        chk("reset_ok_cls", int'(ok_cls), 0);
        chk("reset_nota_cls", int'(nota_cls), 0);
        chk("reset_tom_cls", int'(tom_cls), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_tipo", int'(tipo_out), 0);
        check_regs("reset");

        // Start on an empty buffer is ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("empty_start_busy", int'(busy), 0);
        end

        // Directed: five notes, fim answered two cycles after the last ok.
        for (int i = 1; i <= 5; i++) write_note(i, 1);
        check_regs("five_notes");
        run_phrase(11, 3);

        // Overflow: ninth write dropped and flagged.
        for (int i = 0; i < 9; i++) write_note($urandom_range(0, 7), $urandom_range(0, 1));
        check_regs("overflow");
        run_phrase(1 + (DEPTH - 1) * (GAP + 1) + 1, 2);

        // Early fim right after the third ok.
        for (int i = 0; i < 6; i++) write_note(i + 2, 0);
        run_phrase(1 + 2 * (GAP + 1) + 1, 1);

        // Timeout with two notes.
        write_note(7, 1);
        write_note(6, 1);
        run_phrase(-1, 0);

        // Reset in the middle of a gap.
        for (int i = 0; i < 4; i++) write_note(i + 1, 1);
        begin
            int s;
            s = cyc + 1;
            push_ev(0, s, 0, 0, 0, 0);
            push_ev(1, s + 1, mdl[0], mdl_tom, 0, 0);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            #2 reset = 1'b1;
            #1;
            chk("async_reset_busy", int'(busy), 0);
            chk("async_reset_count", int'(count), 0);
            chk("async_reset_ok", int'(ok_cls), 0);
            chk("async_reset_rst_cls", int'(rst_cls), 0);
            chk("async_reset_nota", int'(nota_cls), 0);
            chk("async_reset_tom", int'(tom_cls), 0);
            chk("async_reset_err", int'(err), 0);
            chk("async_reset_scoreboard", sb.size(), 0);
            sb.delete();
            mdl.delete();
            mdl_err = 0;
            @(negedge clk);
            reset = 1'b0;
            write_note(5, 0);
            chk("write_after_reset_count", int'(count), 1);
        end

        // Randomized phrases.
        for (int p = 0; p < 14; p++) begin
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) write_note($urandom_range(0, 7), $urandom_range(0, 1));
            check_regs("rand_fill");
            lmax = 1 + (mdl.size() - 1) * (GAP + 1);
            if ($urandom_range(0, 3) == 0) run_phrase(-1, 0);
            else run_phrase($urandom_range(1, lmax + TIMEOUT + 1), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
